gb_dma: RTL and testbench
=========================

Name: gb_dma

Overview:
- Parametrised DMA engine that fills the currently tied-off dma_active / adr_dma_rd / adr_dma_wr / rd_dma / wr_dma hooks of the system top.
- Supports two modes:
  - legacy OAM DMA: write to FF46, 160 bytes copied into OAM;
  - general block DMA (GDMA): CGB-style source/destination/length registers, copying 16-byte blocks into VRAM while the CPU is stalled.
- Sits beside the CPU on gbclk. Decoded register selects come from the IO map.

Parameters:
- CYCLES_PER_BYTE, 4, clocks per transferred byte (≥2).
- OAM_LEN, 160, bytes per OAM transfer (≤256).
- DST_WIDTH, 13, width of the destination address bus (VRAM offset).
- MAX_BLOCKS, 128, maximum GDMA length in 16-byte blocks (power of two, ≤128).

Ports:
- clk  in  1  gbclk
- reset  in  1  asynchronous, active-high
- adr  in  3  register offset: 0=OAM src hi, 1=GDMA src hi, 2=src lo, 3=dst hi, 4=dst lo, 5=length/start
- din  in  8  CPU write data
- dout  out  8  register read data
- read  in  1  CPU read strobe
- write  in  1  CPU write strobe
- sel_oam  in  1  FF46 selected
- sel_gdma  in  1  GDMA registers (offsets 1-5) selected
- adr_rd  out  16  DMA source address
- rd  out  1  source read strobe
- data_in  in  8  source read data
- adr_wr  out  DST_WIDTH  destination address (OAM mode uses [7:0])
- data_out  out  8  destination write data
- wr  out  1  destination write strobe
- dst_oam  out  1  1 = destination is OAM, 0 = VRAM
- active  out  1  any transfer in progress
- oam_active  out  1  OAM transfer in progress (blocks CPU OAM access)
- cpu_stall  out  1  GDMA in progress (CPU held)

Behaviour:
- Reset (async, immediate, also mid-transfer):
  - all outputs 0; state IDLE; registers 0; pending flag cleared.
  - A transfer aborted by reset is not resumed.
- States: IDLE, OAM, GDMA, FLUSH.

- Byte slot (CYCLES_PER_BYTE clocks, counter c = 0..C-1):
  - rd=1 for the whole slot.
  - adr_rd = src + index.
  - At c=C-1, data_in is latched.
  - On the next clock (c=0 of the next slot, or FLUSH), wr=1 for exactly one clock, with data_out = latch and adr_wr = previous index.
  - Writes trail reads by one slot.

- OAM start (sel_oam && write):
  - src = {din,8'h00}.
  - If din ≥ 8'hE0, bit 13 of src is cleared (mirrors to C000-DFFF).
  - From IDLE: enter OAM on the next clock.
  - While in OAM: restart from index 0 with the new src. The in-flight trailing write is dropped.
  - While in GDMA: store as pending; start immediately after the GDMA FLUSH completes.
  - Offset-0 read returns the last written value.

- GDMA registers:
  - src = {reg1, reg2[7:4], 4'h0}.
  - dst = {reg3[DST_WIDTH-9:0], reg4[7:4], 4'h0}.
  - Writing offset 5 starts GDMA with length ((din[6:0] mod MAX_BLOCKS) + 1)×16 bytes.
  - A start while active, or while a pending OAM request exists, is ignored.
  - Offset 5 reads {~active_gdma, blocks_remaining-1} while busy and 8'hFF when idle.
  - Offsets 1-4 read 8'hFF.

- Indexing:
  - index is 0..len-1.
  - src+index wraps mod 2^16.
  - dst+index wraps mod 2^DST_WIDTH.

- Completion: after the last read slot, enter FLUSH for one clock carrying the final write.
  - active, oam_active and cpu_stall drop on the clock after FLUSH.
  - oam_active, dst_oam and cpu_stall are valid on the same clock the first rd rises.

- Simultaneous events:
  - A write with both sel_oam and sel_gdma set is treated as OAM only.
  - Register writes during a transfer update registers but do not affect the running transfer, except an OAM restart.

- Latency: the first rd is asserted 1 clock after the start write. An OAM transfer lasts (OAM_LEN×C + 1) clocks of active.

Test Plan:
- OAM copy: preload C000-C09F with i^8'h5A, write 8'hC0 to FF46 → 160 wr pulses, adr_wr 0..159, data_out = i^8'h5A; active high for 641 clocks at C=4.
- Mirror: write 8'hFE → adr_rd starts at 8'hDE00; readback at offset 0 = 8'hFE.
- Restart: second OAM write at byte 50 with 8'hD0 → next rd at D000, adr_wr restarts at 0, 160 further writes, no write with index 50 from the old source.
- GDMA: src 8'h4000, dst 8'h0100, write 8'h01 to offset 5 → 32 bytes to VRAM 0100-011F, cpu_stall high throughout; offset 5 reads 8'h00 after the first block, then 8'hFF when done.
- Pending OAM: OAM write during GDMA → OAM starts the clock after GDMA FLUSH; a GDMA start attempted meanwhile is ignored.
- Async reset at byte 10 of an OAM transfer → active, rd, wr drop without a clock edge; no further writes after release.

Source files
------------

// File: rtl/gb_dma.sv
// gb_dma: DMA engine sitting beside the CPU on gbclk.
//
// Two transfer kinds share one byte-slot datapath:
//   - OAM DMA  : a write to FF46 copies OAM_LEN bytes from {page,8'h00} into OAM.
//   - GDMA     : CGB-style block copy of 16-byte blocks into VRAM, CPU stalled.
//
// Each byte occupies CYCLES_PER_BYTE clocks with rd_o held high. The source
// byte is captured on the last clock of its slot and written out on the
// following clock, so writes trail reads by one slot. A single FLUSH clock
// after the last read carries the final write.
//
// Ports:
//   clk_i, reset_i       gbclk, asynchronous active-high reset
//   adr_i                register offset (0 OAM src hi, 1 GDMA src hi, 2 src lo,
//                        3 dst hi, 4 dst lo, 5 length/start)
//   din_i / dout_o       CPU write data / register read data
//   read_i, write_i      CPU strobes
//   sel_oam_i            FF46 selected
//   sel_gdma_i           GDMA registers selected
//   adr_rd_o, rd_o       source address and read strobe
//   data_in_i            source read data
//   adr_wr_o, wr_o       destination address and write strobe
//   data_out_o           destination write data
//   dst_oam_o            1 = destination is OAM, 0 = VRAM
//   active_o             any transfer in progress
//   oam_active_o         OAM transfer in progress
//   cpu_stall_o          GDMA in progress, CPU held
module gb_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int OAM_LEN         = 160,
  parameter int DST_WIDTH       = 13,
  parameter int MAX_BLOCKS      = 128
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [2:0]           adr_i,
  input  logic [7:0]           din_i,
  output logic [7:0]           dout_o,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic                 sel_oam_i,
  input  logic                 sel_gdma_i,
  output logic [15:0]          adr_rd_o,
  output logic                 rd_o,
  input  logic [7:0]           data_in_i,
  output logic [DST_WIDTH-1:0] adr_wr_o,
  output logic [7:0]           data_out_o,
  output logic                 wr_o,
  output logic                 dst_oam_o,
  output logic                 active_o,
  output logic                 oam_active_o,
  output logic                 cpu_stall_o
);

  localparam int CW    = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int IDX_W = 11;

  localparam logic [CW-1:0]    LAST_CYC = CW'(CYCLES_PER_BYTE - 1);
  localparam logic [IDX_W-1:0] OAM_LAST = IDX_W'(OAM_LEN - 1);
  localparam logic [6:0]       BLK_MASK = 7'(MAX_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    OAM,
    GDMA,
    FLUSH
  } state_t;

  // CPU-visible registers; only the bits that feed an address are kept
  logic [7:0]           oamReg_q;
  logic [7:0]           srcHi_q;
  logic [3:0]           srcLo_q;
  logic [DST_WIDTH-9:0] dstHi_q;
  logic [3:0]           dstLo_q;

  // Transfer state
  state_t               state_q;
  logic [15:0]          xferSrc_q;
  logic [DST_WIDTH-1:0] xferDst_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     lastIdx_q;
  logic [CW-1:0]        cyc_q;
  logic                 pend_q;
  logic [15:0]          pendSrc_q;

  // Registered outputs
  logic [15:0]          adr_rd_q;
  logic                 rd_q;
  logic [DST_WIDTH-1:0] adr_wr_q;
  logic [7:0]           data_out_q;
  logic                 wr_q;
  logic                 dst_oam_q;
  logic                 active_q;
  logic                 oam_active_q;
  logic                 cpu_stall_q;

  logic                 oamWr_d;
  logic                 gdmaWr_d;
  logic [15:0]          oamSrc_d;
  logic [15:0]          gdmaSrc_d;
  logic [DST_WIDTH-1:0] gdmaDst_d;
  logic                 startOam_d;
  logic [15:0]          startSrc_d;
  logic                 gdmaStart_d;

  // A write with both selects set counts as an OAM write only
  assign oamWr_d  = sel_oam_i && write_i;
  assign gdmaWr_d = sel_gdma_i && write_i && !sel_oam_i;

  // Pages E0-FF mirror onto C000-DFFF, so bit 13 of the source is cleared
  assign oamSrc_d  = {(din_i >= 8'hE0) ? {din_i[7:6], 1'b0, din_i[4:0]} : din_i, 8'h00};
  assign gdmaSrc_d = {srcHi_q, srcLo_q, 4'h0};
  assign gdmaDst_d = {dstHi_q, dstLo_q, 4'h0};

  // OAM starts from idle, restarts a running OAM copy, or launches straight
  // out of FLUSH (fresh request or one held pending behind a GDMA)
  assign startOam_d = (oamWr_d && (state_q != GDMA)) || ((state_q == FLUSH) && pend_q);
  assign startSrc_d = oamWr_d ? oamSrc_d : pendSrc_q;
  assign gdmaStart_d = gdmaWr_d && (adr_i == 3'd5) && (state_q == IDLE) && !pend_q;

  assign adr_rd_o     = adr_rd_q;
  assign rd_o         = rd_q;
  assign adr_wr_o     = adr_wr_q;
  assign data_out_o   = data_out_q;
  assign wr_o         = wr_q;
  assign dst_oam_o    = dst_oam_q;
  assign active_o     = active_q;
  assign oam_active_o = oam_active_q;
  assign cpu_stall_o  = cpu_stall_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      oamReg_q <= '0;
      srcHi_q  <= '0;
      srcLo_q  <= '0;
      dstHi_q  <= '0;
      dstLo_q  <= '0;
    end else if (oamWr_d) begin
      oamReg_q <= din_i;
    end else if (gdmaWr_d) begin
      case (adr_i)
        3'd1:    srcHi_q <= din_i;
        3'd2:    srcLo_q <= din_i[7:4];
        3'd3:    dstHi_q <= din_i[DST_WIDTH-9:0];
        3'd4:    dstLo_q <= din_i[7:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      xferSrc_q    <= '0;
      xferDst_q    <= '0;
      idx_q        <= '0;
      lastIdx_q    <= '0;
      cyc_q        <= '0;
      pend_q       <= 1'b0;
      pendSrc_q    <= '0;
      adr_rd_q     <= '0;
      rd_q         <= 1'b0;
      adr_wr_q     <= '0;
      data_out_q   <= '0;
      wr_q         <= 1'b0;
      dst_oam_q    <= 1'b0;
      active_q     <= 1'b0;
      oam_active_q <= 1'b0;
      cpu_stall_q  <= 1'b0;
    end else begin
      // Write strobe is a single-clock pulse unless a slot boundary re-arms it
      wr_q <= 1'b0;

      if ((state_q == GDMA) && oamWr_d) begin
        pend_q    <= 1'b1;
        pendSrc_q <= oamSrc_d;
      end

      if (startOam_d) begin
        // A restart lands here too; the default above drops the trailing write
        state_q      <= OAM;
        pend_q       <= 1'b0;
        xferSrc_q    <= startSrc_d;
        xferDst_q    <= '0;
        idx_q        <= '0;
        lastIdx_q    <= OAM_LAST;
        cyc_q        <= '0;
        rd_q         <= 1'b1;
        adr_rd_q     <= startSrc_d;
        active_q     <= 1'b1;
        oam_active_q <= 1'b1;
        dst_oam_q    <= 1'b1;
        cpu_stall_q  <= 1'b0;
      end else if (gdmaStart_d) begin
        state_q      <= GDMA;
        xferSrc_q    <= gdmaSrc_d;
        xferDst_q    <= gdmaDst_d;
        idx_q        <= '0;
        lastIdx_q    <= {din_i[6:0] & BLK_MASK, 4'hF};
        cyc_q        <= '0;
        rd_q         <= 1'b1;
        adr_rd_q     <= gdmaSrc_d;
        active_q     <= 1'b1;
        oam_active_q <= 1'b0;
        dst_oam_q    <= 1'b0;
        cpu_stall_q  <= 1'b1;
      end else begin
        case (state_q)
          OAM, GDMA: begin
            if (cyc_q == LAST_CYC) begin
              // Capture the byte and present it as next clock's write
              wr_q       <= 1'b1;
              data_out_q <= data_in_i;
              adr_wr_q   <= xferDst_q + DST_WIDTH'(idx_q);
              cyc_q      <= '0;
              if (idx_q == lastIdx_q) begin
                state_q <= FLUSH;
                rd_q    <= 1'b0;
              end else begin
                idx_q    <= idx_q + IDX_W'(1);
                adr_rd_q <= xferSrc_q + 16'(idx_q + IDX_W'(1));
              end
            end else begin
              cyc_q <= cyc_q + CW'(1);
            end
          end
          FLUSH: begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            oam_active_q <= 1'b0;
            dst_oam_q    <= 1'b0;
            cpu_stall_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Offset 5 reports blocks still to go minus one while a GDMA runs;
  // cpu_stall is high for exactly the GDMA and its FLUSH clock
  always_comb begin
    dout_o = 8'h00;
    if (read_i && !reset_i) begin
      if (sel_oam_i) begin
        dout_o = oamReg_q;
      end else if (sel_gdma_i) begin
        if ((adr_i == 3'd5) && cpu_stall_q) begin
          dout_o = {1'b0, 7'(lastIdx_q[IDX_W-1:4] - idx_q[IDX_W-1:4])};
        end else begin
          dout_o = 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_dma.sv
// tb_gb_dma: directed + randomized bench for gb_dma. Expected write streams
// are derived from a flat 64 KiB source memory and the transfer rules
// (source page, mirror, block counts, wrap), then compared against every
// write pulse the DUT emits.
module tb_gb_dma;

  localparam int C       = 4;
  localparam int OAM_LEN = 160;
  localparam int DW      = 13;
  localparam int MAXB    = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    adr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          read;
  logic          write;
  logic          selOam;
  logic          selGdma;
  logic [15:0]   adrRd;
  logic          rd;
  logic [7:0]    dataIn;
  logic [DW-1:0] adrWr;
  logic [7:0]    dataOut;
  logic          wr;
  logic          dstOam;
  logic          active;
  logic          oamActive;
  logic          cpuStall;

  logic [7:0]    mem [0:65535];
  logic [20:0]   actWr[$];
  logic [20:0]   expWr[$];

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  assign dataIn = mem[adrRd];

  gb_dma #(
    .CYCLES_PER_BYTE(C),
    .OAM_LEN(OAM_LEN),
    .DST_WIDTH(DW),
    .MAX_BLOCKS(MAXB)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .adr_i(adr),
    .din_i(din),
    .dout_o(dout),
    .read_i(read),
    .write_i(write),
    .sel_oam_i(selOam),
    .sel_gdma_i(selGdma),
    .adr_rd_o(adrRd),
    .rd_o(rd),
    .data_in_i(dataIn),
    .adr_wr_o(adrWr),
    .data_out_o(dataOut),
    .wr_o(wr),
    .dst_oam_o(dstOam),
    .active_o(active),
    .oam_active_o(oamActive),
    .cpu_stall_o(cpuStall)
  );

  // Record every destination write as {address, data}
  always @(negedge clk) begin
    if (wr) actWr.push_back({adrWr, dataOut});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isOam, input logic [2:0] a, input logic [7:0] d);
    selOam  = isOam;
    selGdma = !isOam;
    adr     = a;
    din     = d;
    write   = 1'b1;
    stepCycle();
    write   = 1'b0;
    selOam  = 1'b0;
    selGdma = 1'b0;
  endtask

  task automatic readReg(input logic isOam, input logic [2:0] a, output logic [7:0] v);
    selOam  = isOam;
    selGdma = !isOam;
    adr     = a;
    read    = 1'b1;
    #1;
    v       = dout;
    read    = 1'b0;
    selOam  = 1'b0;
    selGdma = 1'b0;
  endtask

  task automatic waitWrites(input int n, input int budget);
    int k = 0;
    while (actWr.size() < n && k < budget) begin
      k++;
      stepCycle();
    end
    checkOutput($sformatf("waitWrites%0d", n), 32'(actWr.size() >= n), 32'd1);
  endtask

  // Runs until active drops, counting active clocks and clocks whose mode
  // flags disagree with the expected transfer kind
  task automatic waitIdle(input int budget, input logic expStall, input logic expOam,
                          output int cycles, output int modeErr);
    cycles  = 0;
    modeErr = 0;
    while (active && cycles < budget) begin
      if (cpuStall !== expStall || oamActive !== expOam || dstOam !== expOam) modeErr++;
      cycles++;
      stepCycle();
    end
  endtask

  function automatic logic [15:0] oamPageSrc(input logic [7:0] d);
    int page;
    page = (d >= 8'hE0) ? int'(d) - 32 : int'(d);
    return 16'(page * 256);
  endfunction

  task automatic pushOam(input logic [15:0] src, input int count);
    for (int i = 0; i < count; i++)
      expWr.push_back({DW'(i), mem[(int'(src) + i) % 65536]});
  endtask

  task automatic pushGdma(input logic [15:0] src, input int dst, input int len);
    for (int i = 0; i < len; i++)
      expWr.push_back({DW'((dst + i) % (1 << DW)), mem[(int'(src) + i) % 65536]});
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, ".count"}, 32'(actWr.size()), 32'(expWr.size()));
    n = (actWr.size() < expWr.size()) ? actWr.size() : expWr.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(actWr[i]), 32'(expWr[i]));
    actWr.delete();
    expWr.delete();
  endtask

  initial begin
    logic [7:0]  v;
    logic [7:0]  page;
    logic [7:0]  r1, r2, r3, r4, lenByte;
    logic [15:0] src;
    int          dst, blocks, cycles, modeErr, k;
    logic        prevRd, prevWr;

    reset   = 1'b1;
    adr     = '0;
    din     = '0;
    read    = 1'b0;
    write   = 1'b0;
    selOam  = 1'b0;
    selGdma = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < OAM_LEN; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst.active", 32'(active), 32'd0);
    checkOutput("rst.rd", 32'(rd), 32'd0);
    checkOutput("rst.wr", 32'(wr), 32'd0);
    checkOutput("rst.adrRd", 32'(adrRd), 32'd0);
    checkOutput("rst.adrWr", 32'(adrWr), 32'd0);
    checkOutput("rst.dataOut", 32'(dataOut), 32'd0);
    checkOutput("rst.flags", 32'({dstOam, oamActive, cpuStall}), 32'd0);
    reset = 1'b0;
    stepCycle();
    readReg(1'b0, 3'd5, v);
    checkOutput("rst.read5", 32'(v), 32'hFF);
    readReg(1'b1, 3'd0, v);
    checkOutput("rst.read0", 32'(v), 32'h00);
    actWr.delete();

    // OAM copy from C000
    $display("[TB] OAM copy from C000");
    applyStimulus(1'b1, 3'd0, 8'hC0);
    checkOutput("oam.firstRd", 32'({rd, adrRd}), 32'({1'b1, 16'hC000}));
    pushOam(16'hC000, OAM_LEN);
    waitIdle(2000, 1'b0, 1'b1, cycles, modeErr);
    checkOutput("oam.activeCycles", 32'(cycles), 32'(OAM_LEN * C + 1));
    checkOutput("oam.modeFlags", 32'(modeErr), 32'd0);
    compareWrites("oamCopy");

    // Mirror page FE plus one random page
    $display("[TB] OAM mirror");
    applyStimulus(1'b1, 3'd0, 8'hFE);
    checkOutput("mirror.firstRd", 32'(adrRd), 32'hDE00);
    readReg(1'b1, 3'd0, v);
    checkOutput("mirror.read0", 32'(v), 32'hFE);
    pushOam(16'hDE00, OAM_LEN);
    waitIdle(2000, 1'b0, 1'b1, cycles, modeErr);
    compareWrites("mirror");
    page = 8'($urandom);
    applyStimulus(1'b1, 3'd0, page);
    checkOutput("randPage.firstRd", 32'(adrRd), 32'(oamPageSrc(page)));
    pushOam(oamPageSrc(page), OAM_LEN);
    waitIdle(2000, 1'b0, 1'b1, cycles, modeErr);
    checkOutput("randPage.modeFlags", 32'(modeErr), 32'd0);
    compareWrites("randPage");

    // Restart at byte 50 with page D0
    $display("[TB] OAM restart");
    page = 8'($urandom_range(0, 8'hDF));
    applyStimulus(1'b1, 3'd0, page);
    pushOam(oamPageSrc(page), 50);
    waitWrites(50, 1000);
    applyStimulus(1'b1, 3'd0, 8'hD0);
    checkOutput("restart.firstRd", 32'({rd, adrRd}), 32'({1'b1, 16'hD000}));
    pushOam(16'hD000, OAM_LEN);
    waitIdle(2000, 1'b0, 1'b1, cycles, modeErr);
    checkOutput("restart.activeCycles", 32'(cycles), 32'(OAM_LEN * C + 1));
    compareWrites("restart");

    // GDMA 4000 -> 0100, two blocks
    $display("[TB] GDMA fixed");
    applyStimulus(1'b0, 3'd1, 8'h40);
    applyStimulus(1'b0, 3'd2, 8'h00);
    applyStimulus(1'b0, 3'd3, 8'h01);
    applyStimulus(1'b0, 3'd4, 8'h00);
    applyStimulus(1'b0, 3'd5, 8'h01);
    checkOutput("gdma.firstRd", 32'({rd, adrRd}), 32'({1'b1, 16'h4000}));
    checkOutput("gdma.flags", 32'({cpuStall, oamActive, dstOam}), 32'b100);
    readReg(1'b0, 3'd5, v);
    checkOutput("gdma.read5Start", 32'(v), 32'(2 - 1 - actWr.size() / 16));
    waitWrites(16, 1000);
    readReg(1'b0, 3'd5, v);
    checkOutput("gdma.read5Block1", 32'(v), 32'(2 - 1 - actWr.size() / 16));
    readReg(1'b0, 3'd1, v);
    checkOutput("gdma.read1", 32'(v), 32'hFF);
    waitIdle(2000, 1'b1, 1'b0, cycles, modeErr);
    checkOutput("gdma.modeFlags", 32'(modeErr), 32'd0);
    readReg(1'b0, 3'd5, v);
    checkOutput("gdma.read5Done", 32'(v), 32'hFF);
    pushGdma(16'h4000, 16'h0100, 32);
    compareWrites("gdmaFixed");

    // Randomized GDMA: plain, wrapping at both ends, and maximum length
    for (int round = 0; round < 3; round++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      r4 = 8'($urandom);
      lenByte = {1'($urandom), 5'b0, 2'($urandom)};
      if (round == 1) begin
        r1 = 8'hFF; r2 = 8'hF7; r3 = 8'hFF; r4 = 8'hF3; lenByte = 8'h81;
      end
      if (round == 2) lenByte = 8'hFF;
      $display("[TB] GDMA random round %0d", round);
      applyStimulus(1'b0, 3'd1, r1);
      applyStimulus(1'b0, 3'd2, r2);
      applyStimulus(1'b0, 3'd3, r3);
      applyStimulus(1'b0, 3'd4, r4);
      applyStimulus(1'b0, 3'd5, lenByte);
      src    = 16'(int'(r1) * 256 + (int'(r2) / 16) * 16);
      dst    = (int'(r3) * 256 + (int'(r4) / 16) * 16) % (1 << DW);
      blocks = (int'(lenByte) % 128) % MAXB + 1;
      checkOutput($sformatf("gdmaRand%0d.firstRd", round), 32'(adrRd), 32'(src));
      waitIdle(20000, 1'b1, 1'b0, cycles, modeErr);
      checkOutput($sformatf("gdmaRand%0d.activeCycles", round), 32'(cycles),
                  32'(blocks * 16 * C + 1));
      checkOutput($sformatf("gdmaRand%0d.modeFlags", round), 32'(modeErr), 32'd0);
      pushGdma(src, dst, blocks * 16);
      compareWrites($sformatf("gdmaRand%0d", round));
    end

    // OAM request pending behind a GDMA; a second GDMA start is ignored
    $display("[TB] pending OAM");
    r1 = 8'($urandom);
    r3 = 8'($urandom);
    applyStimulus(1'b0, 3'd1, r1);
    applyStimulus(1'b0, 3'd2, 8'h00);
    applyStimulus(1'b0, 3'd3, r3);
    applyStimulus(1'b0, 3'd4, 8'h00);
    applyStimulus(1'b0, 3'd5, 8'h01);
    src = 16'(int'(r1) * 256);
    dst = (int'(r3) * 256) % (1 << DW);
    waitWrites(5, 1000);
    page = 8'($urandom_range(0, 8'hDF));
    applyStimulus(1'b1, 3'd0, page);
    checkOutput("pend.held", 32'({cpuStall, oamActive}), 32'b10);
    applyStimulus(1'b0, 3'd5, 8'h03);
    prevRd = 1'b0;
    prevWr = 1'b0;
    k = 0;
    while (cpuStall && k < 2000) begin
      prevRd = rd;
      prevWr = wr;
      k++;
      stepCycle();
    end
    checkOutput("pend.flushBefore", 32'({prevRd, prevWr}), 32'b01);
    checkOutput("pend.oamStart", 32'({active, oamActive, rd, adrRd}),
                32'({1'b1, 1'b1, 1'b1, oamPageSrc(page)}));
    waitIdle(2000, 1'b0, 1'b1, cycles, modeErr);
    checkOutput("pend.oamCycles", 32'(cycles), 32'(OAM_LEN * C + 1));
    pushGdma(src, dst, 32);
    pushOam(oamPageSrc(page), OAM_LEN);
    compareWrites("pending");

    // Asynchronous reset at byte 10 of an OAM copy
    $display("[TB] async reset mid-transfer");
    page = 8'($urandom_range(0, 8'hDF));
    applyStimulus(1'b1, 3'd0, page);
    pushOam(oamPageSrc(page), 10);
    waitWrites(10, 1000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst.active", 32'(active), 32'd0);
    checkOutput("arst.rd", 32'(rd), 32'd0);
    checkOutput("arst.wr", 32'(wr), 32'd0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    repeat (700) stepCycle();
    checkOutput("arst.activeAfter", 32'(active), 32'd0);
    readReg(1'b1, 3'd0, v);
    checkOutput("arst.read0", 32'(v), 32'h00);
    compareWrites("asyncReset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
